mem_wb_stage: RTL and testbench

// - Parametrised MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush, and

---
 rtl/mem_wb_stage_if.sv | 50 +++++
 rtl/mem_wb_stage.sv | 131 +++++++++++++
 tb/tb_mem_wb_stage.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bundle: upstream entry fields, downstream write-back port, flush.
// Forwarding signals exist only when MEM_WB_FWD_EN is defined.
interface mem_wb_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  localparam int OFF_W = $clog2(XLEN/8);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // once valid is raised its payload stays stable until that transfer.
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [RA_W-1:0]   rd;
  logic [XLEN-1:0]   result;
  logic [XLEN-1:0]   memOut;
  logic              Wreg;
  logic              mem_to_reg;
  logic [1:0]        ld_size;
  logic              ld_unsigned;
  logic [OFF_W-1:0]  byte_off;
  logic              out_valid;
  logic              out_ready;
  logic [RA_W-1:0]   rd_out;
  logic [XLEN-1:0]   wb_data_out;
  logic              Wreg_out;
`ifdef MEM_WB_FWD_EN
  logic              fwd_valid;
  logic [RA_W-1:0]   fwd_rd;
  logic [XLEN-1:0]   fwd_data;
`endif

  modport slave (
`ifdef MEM_WB_FWD_EN
    output fwd_valid, fwd_rd, fwd_data,
`endif
    input  flush, in_valid, rd, result, memOut, Wreg, mem_to_reg,
    input  ld_size, ld_unsigned, byte_off, out_ready,
    output in_ready, out_valid, rd_out, wb_data_out, Wreg_out
  );

  modport master (
`ifdef MEM_WB_FWD_EN
    input  fwd_valid, fwd_rd, fwd_data,
`endif
    output flush, in_valid, rd, result, memOut, Wreg, mem_to_reg,
    output ld_size, ld_unsigned, byte_off, out_ready,
    input  in_ready, out_valid, rd_out, wb_data_out, Wreg_out
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with 2-entry skid buffer, flush and load formatting.
// Optional MEM_WB_FWD_EN adds forwarding outputs mirroring the write port.
module mem_wb_stage #(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int ZERO_RD = 1
) (
  input  logic           Clock,
  input  logic           Reset,
  mem_wb_stage_if.slave  bus
);
  localparam int OFF_W = $clog2(XLEN/8);

  typedef struct packed {
    logic [RA_W-1:0]  rd;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  mem_out;
    logic             wreg;
    logic             mem_to_reg;
    logic [1:0]       ld_size;
    logic             ld_unsigned;
    logic [OFF_W-1:0] byte_off;
  } entry_t;

  entry_t or_q, or_d, sr_q, sr_d, in_entry;
  logic   or_valid_q, or_valid_d, sr_valid_q, sr_valid_d;
  logic   accept;

  always_comb begin
    in_entry.rd          = bus.rd;
    in_entry.result      = bus.result;
    in_entry.mem_out     = bus.memOut;
    in_entry.wreg        = bus.Wreg;
    in_entry.mem_to_reg  = bus.mem_to_reg;
    in_entry.ld_size     = bus.ld_size;
    in_entry.ld_unsigned = bus.ld_unsigned;
    in_entry.byte_off    = bus.byte_off;
  end

  // in_ready is just !sr_valid_q, so accept never depends on out_ready combinationally.
  always_comb begin
    accept     = bus.in_valid & ~sr_valid_q;
    or_d       = or_q;
    or_valid_d = or_valid_q;
    sr_d       = sr_q;
    sr_valid_d = sr_valid_q;
    if (bus.flush) begin
      or_valid_d = 1'b0;
      sr_valid_d = 1'b0;
    end else if (!or_valid_q || bus.out_ready) begin
      if (sr_valid_q) begin
        or_d       = sr_q;
        or_valid_d = 1'b1;
      end else if (accept) begin
        or_d       = in_entry;
        or_valid_d = 1'b1;
      end else begin
        or_valid_d = 1'b0;
      end
      // A full skid blocks accept, so the skid always empties when OR moves.
      sr_valid_d = 1'b0;
    end else if (accept) begin
      sr_d       = in_entry;
      sr_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      or_q       <= '0;
      sr_q       <= '0;
      or_valid_q <= 1'b0;
      sr_valid_q <= 1'b0;
    end else begin
      or_q       <= or_d;
      sr_q       <= sr_d;
      or_valid_q <= or_valid_d;
      sr_valid_q <= sr_valid_d;
    end
  end

  logic [XLEN-1:0] sh, mask, fmt, wb_data;
  logic            sign;
  logic            wreg_out;

  // Mask keeps the loaded field; the complement is filled with the sign bit for signed loads.
  always_comb begin
    sh   = or_q.mem_out >> {or_q.byte_off, 3'b000};
    mask = '1;
    sign = 1'b0;
    case (or_q.ld_size)
      2'd0: begin
        mask = XLEN'(8'hFF);
        sign = sh[7];
      end
      2'd1: begin
        mask = XLEN'(16'hFFFF);
        sign = sh[15];
      end
      2'd2: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sign = sh[31];
      end
      default: begin
        if (XLEN == 64) begin
          mask = '1;
          sign = 1'b0;
        end else begin
          mask = XLEN'(32'hFFFF_FFFF);
          sign = sh[31];
        end
      end
    endcase
    fmt     = (sh & mask) | ({XLEN{sign & ~or_q.ld_unsigned}} & ~mask);
    wb_data = '0;
    if (or_valid_q) wb_data = or_q.mem_to_reg ? fmt : or_q.result;
    wreg_out = or_valid_q & or_q.wreg & ~((ZERO_RD != 0) && (or_q.rd == '0));
  end

  assign bus.in_ready    = ~sr_valid_q;
  assign bus.out_valid   = or_valid_q;
  assign bus.rd_out      = or_q.rd;
  assign bus.wb_data_out = wb_data;
  assign bus.Wreg_out    = wreg_out;

`ifdef MEM_WB_FWD_EN
  assign bus.fwd_valid = wreg_out;
  assign bus.fwd_rd    = or_q.rd;
  assign bus.fwd_data  = wb_data;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus random traffic vs. a queue model.
module tb_mem_wb_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  mem_wb_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  mem_wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .ZERO_RD(1)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [RA_W-1:0] rd;
    logic [31:0]     result;
    logic [31:0]     mem;
    logic            wreg;
    logic            m2r;
    logic [1:0]      size;
    logic            uns;
    logic [1:0]      off;
  } ent_t;

  ent_t            model_q[$];
  logic [RA_W-1:0] last_rd = '0;
  int              total = 0;
  int              bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Load result built from C-like typed extension of the addressed bytes.
  function automatic logic [31:0] ref_wb(input ent_t e);
    logic [31:0] b;
    byte         sb;
    shortint     sh16;
    int          r;
    if (!e.m2r) return e.result;
    b = e.mem >> (8 * e.off);
    case (e.size)
      2'd0: begin
        sb = b[7:0];
        r  = e.uns ? int'({24'd0, b[7:0]}) : int'(sb);
      end
      2'd1: begin
        sh16 = b[15:0];
        r    = e.uns ? int'({16'd0, b[15:0]}) : int'(sh16);
      end
      default: r = b;
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [RA_W-1:0] rd, input logic [31:0] res,
                       input logic [31:0] mem, input logic wreg, input logic m2r,
                       input logic [1:0] size, input logic uns, input logic [1:0] off,
                       input logic fl, input logic ordy);
    bus.in_valid    = v;
    bus.rd          = rd;
    bus.result      = res;
    bus.memOut      = mem;
    bus.Wreg        = wreg;
    bus.mem_to_reg  = m2r;
    bus.ld_size     = size;
    bus.ld_unsigned = uns;
    bus.byte_off    = off;
    bus.flush       = fl;
    bus.out_ready   = ordy;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, ordy);
  endtask

  task automatic model_edge();
    ent_t e;
    bit   acc;
    if (Reset) begin
      model_q.delete();
      last_rd = '0;
    end else if (bus.flush) begin
      model_q.delete();
    end else begin
      acc = bus.in_valid && (model_q.size() < 2);
      if (model_q.size() > 0 && bus.out_ready) void'(model_q.pop_front());
      if (acc) begin
        e.rd = bus.rd; e.result = bus.result; e.mem = bus.memOut; e.wreg = bus.Wreg;
        e.m2r = bus.mem_to_reg; e.size = bus.ld_size; e.uns = bus.ld_unsigned; e.off = bus.byte_off;
        model_q.push_back(e);
      end
    end
    if (model_q.size() > 0) last_rd = model_q[0].rd;
  endtask

  task automatic compare_all();
    bit vld;
    vld = model_q.size() > 0;
    check("out_valid", 64'(bus.out_valid), 64'(vld));
    check("in_ready", 64'(bus.in_ready), 64'(model_q.size() < 2));
    check("rd_out", 64'(bus.rd_out), 64'(last_rd));
    check("wb_data", 64'(bus.wb_data_out), vld ? 64'(ref_wb(model_q[0])) : 64'd0);
    check("wreg_out", 64'(bus.Wreg_out),
          64'(vld && model_q[0].wreg && model_q[0].rd != 0));
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    idle(1'b1);
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    step();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_wb_data", 64'(bus.wb_data_out), 64'd0);
    check("rst_wreg_out", 64'(bus.Wreg_out), 64'd0);

    drive(1'b1, 5'd5, 32'h1234, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    check("alu_rd_out", 64'(bus.rd_out), 64'd5);
    check("alu_wb", 64'(bus.wb_data_out), 64'h1234);
    check("alu_wreg", 64'(bus.Wreg_out), 64'd1);

    drive(1'b1, 5'd7, 32'h0, 32'h80FF7F01, 1'b1, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 1'b1);
    step();
    check("lb_signed", 64'(bus.wb_data_out), 64'hFFFF_FF80);
    drive(1'b1, 5'd7, 32'h0, 32'h80FF7F01, 1'b1, 1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 1'b1);
    step();
    check("lb_unsigned", 64'(bus.wb_data_out), 64'h0000_0080);
    drive(1'b1, 5'd8, 32'h0, 32'h80FF7F01, 1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1);
    step();
    check("lh_signed", 64'(bus.wb_data_out), 64'hFFFF_FF7F);
    drive(1'b1, 5'd8, 32'h0, 32'h80FF7F01, 1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    check("ld_as_word", 64'(bus.wb_data_out), 64'h80FF_7F01);
    idle(1'b1);
    step();

    // Backpressure: A in OR, B in skid, C held upstream until the stage opens.
    drive(1'b1, 5'd1, 32'hA, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd2, 32'hB, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd3, 32'hC, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    check("bp_hold_a", 64'(bus.wb_data_out), 64'hA);
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    check("bp_emit_b", 64'(bus.wb_data_out), 64'hB);
    step();
    check("bp_emit_c", 64'(bus.wb_data_out), 64'hC);
    idle(1'b1);
    step();
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Flush with both registers full and a same-cycle offer.
    drive(1'b1, 5'd4, 32'hD, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd6, 32'hE, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd9, 32'hF, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    check("fl_out_valid", 64'(bus.out_valid), 64'd0);
    check("fl_in_ready", 64'(bus.in_ready), 64'd1);
    check("fl_wreg", 64'(bus.Wreg_out), 64'd0);
    check("fl_wb_zero", 64'(bus.wb_data_out), 64'd0);

    drive(1'b1, 5'd0, 32'h55, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    check("rd0_valid", 64'(bus.out_valid), 64'd1);
    check("rd0_wreg", 64'(bus.Wreg_out), 64'd0);
    idle(1'b1);
    step();

    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), RA_W'($urandom_range(0, 31)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) != 0));
      Reset = ($urandom_range(0, 99) == 0);
      step();
    end
    Reset = 1'b0;
    idle(1'b1);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
